ahmes_mem: RTL and testbench

AHMES_MEM -- requirements
Module: ahmes_mem

---
 rtl/ahmes_mem.sv | 128 ++++++++++++
 tb/tb_ahmes_mem.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahmes_mem.sv
// Ahmes program/data memory: 256x8 store with a registered instruction port, a data port and a byte-stream program loader.
// Optional macro AHMES_MEM_CHECKSUM_EN adds ld_sum, the modulo-256 sum of the bytes written by the current load.
module ahmes_mem #(
    parameter logic [7:0] LOAD_BASE = 8'h00,
    parameter logic [7:0] NOP_BYTE  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_addr,
    output logic [7:0] instr_bus,
    input  logic [7:0] address_bus,
    input  logic [7:0] data_out,
    input  logic       mem_we,
    input  logic       mem_re,
    output logic [7:0] data_bus,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       cpu_hold,
    output logic [8:0] ld_count,
    output logic       ld_overflow
`ifdef AHMES_MEM_CHECKSUM_EN
    ,
    output logic [7:0] ld_sum
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] mem [0:255];
    logic [7:0] ptr_reg;
    logic       load_entry;
    logic       xfer;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    always_comb begin
        state_next = state_reg;
        load_entry = 1'b0;
        xfer       = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = address_bus;
        wr_data    = data_out;
        case (state_reg)
            RUN: begin
                wr_en = mem_we;
                if (ld_start) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                xfer    = ld_valid;
                wr_en   = ld_valid;
                wr_addr = ptr_reg;
                wr_data = ld_data;
                if (ld_valid && ld_last) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign ld_ready = (state_reg == LOAD);
    assign cpu_hold = (state_reg == LOAD);

    // Contents are never reset so a load interrupted by reset keeps what it wrote.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            instr_bus   <= NOP_BYTE;
            data_bus    <= 8'h00;
            ptr_reg     <= LOAD_BASE;
            ld_count    <= 9'd0;
            ld_overflow <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RUN && !ld_start) begin
                instr_bus <= mem[pc_addr];
            end else begin
                instr_bus <= NOP_BYTE;
            end
            if (state_reg == RUN && mem_re) begin
                data_bus <= mem[address_bus];
            end
            if (load_entry) begin
                ptr_reg     <= LOAD_BASE;
                ld_count    <= 9'd0;
                ld_overflow <= 1'b0;
            end else if (xfer) begin
                ptr_reg <= ptr_reg + 8'd1;
                if (ld_count == 9'd256) begin
                    ld_overflow <= 1'b1;
                end else begin
                    ld_count <= ld_count + 9'd1;
                end
            end
        end
    end

`ifdef AHMES_MEM_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_sum <= 8'h00;
        end else if (load_entry) begin
            ld_sum <= 8'h00;
        end else if (xfer) begin
            ld_sum <= ld_sum + ld_data;
        end
    end
`endif

endmodule

// File: tb/tb_ahmes_mem.sv
// Randomized self-checking bench for ahmes_mem against a transaction-level memory/loader model.
module tb_ahmes_mem;

    localparam logic [7:0] LB  = 8'h40;
    localparam logic [7:0] NOP = 8'hEA;

    logic       clk;
    logic       reset;
    logic [7:0] pc_addr;
    logic [7:0] instr_bus;
    logic [7:0] address_bus;
    logic [7:0] data_out;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] data_bus;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       cpu_hold;
    logic [8:0] ld_count;
    logic       ld_overflow;
`ifdef AHMES_MEM_CHECKSUM_EN
    logic [7:0] ld_sum;
`endif

    ahmes_mem #(.LOAD_BASE(LB), .NOP_BYTE(NOP)) dut (
        .clk(clk),
        .reset(reset),
        .pc_addr(pc_addr),
        .instr_bus(instr_bus),
        .address_bus(address_bus),
        .data_out(data_out),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .data_bus(data_bus),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .ld_ready(ld_ready),
        .cpu_hold(cpu_hold),
        .ld_count(ld_count),
        .ld_overflow(ld_overflow)
`ifdef AHMES_MEM_CHECKSUM_EN
        ,
        .ld_sum(ld_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_mem [0:255];
    logic [7:0] m_ptr;
    int         m_count;
    logic       m_ovf;
    logic       m_load;
    logic [7:0] m_instr;
    logic [7:0] m_data;
`ifdef AHMES_MEM_CHECKSUM_EN
    logic [7:0] m_sum;
`endif

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hold"},  32'(cpu_hold),    32'(m_load));
        check({tag, ".ready"}, 32'(ld_ready),    32'(m_load));
        check({tag, ".instr"}, 32'(instr_bus),   32'(m_instr));
        check({tag, ".data"},  32'(data_bus),    32'(m_data));
        check({tag, ".count"}, 32'(ld_count),    32'(m_count));
        check({tag, ".ovf"},   32'(ld_overflow), 32'(m_ovf));
`ifdef AHMES_MEM_CHECKSUM_EN
        check({tag, ".sum"},   32'(ld_sum),      32'(m_sum));
`endif
    endtask

    task automatic idle_inputs;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
    endtask

    task automatic model_reset;
        m_load  = 1'b0;
        m_ptr   = LB;
        m_count = 0;
        m_ovf   = 1'b0;
        m_instr = NOP;
        m_data  = 8'h00;
`ifdef AHMES_MEM_CHECKSUM_EN
        m_sum   = 8'h00;
`endif
    endtask

    task automatic run_op(input logic [7:0] pc, input logic [7:0] addr, input logic [7:0] din,
                          input logic we, input logic re);
        idle_inputs();
        pc_addr     = pc;
        address_bus = addr;
        data_out    = din;
        mem_we      = we;
        mem_re      = re;
        m_instr = m_mem[pc];
        if (re) m_data = m_mem[addr];
        if (we) m_mem[addr] = din;
        tick();
        check_all("run");
        idle_inputs();
    endtask

    // Port activity the loader must ignore while in LOAD.
    task automatic junk;
        pc_addr     = 8'($urandom);
        address_bus = 8'($urandom);
        data_out    = 8'($urandom);
        mem_we      = 1'($urandom_range(0, 1));
        mem_re      = 1'($urandom_range(0, 1));
        ld_start    = 1'($urandom_range(0, 1));
    endtask

    task automatic start_load;
        idle_inputs();
        pc_addr  = 8'($urandom);
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = 8'($urandom);
        ld_last  = 1'($urandom_range(0, 1));
        ld_start = 1'b1;
        m_load  = 1'b1;
        m_ptr   = LB;
        m_count = 0;
        m_ovf   = 1'b0;
        m_instr = NOP;
`ifdef AHMES_MEM_CHECKSUM_EN
        m_sum   = 8'h00;
`endif
        tick();
        check_all("start");
        idle_inputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            junk();
            ld_valid = 1'b0;
            tick();
            check_all("gap");
        end
        junk();
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        m_mem[m_ptr] = b;
        m_ptr = m_ptr + 8'd1;
        if (m_count == 256) m_ovf = 1'b1;
        else m_count++;
`ifdef AHMES_MEM_CHECKSUM_EN
        m_sum = m_sum + b;
`endif
        if (last) m_load = 1'b0;
        m_instr = NOP;
        tick();
        check_all(last ? "last" : "byte");
        idle_inputs();
    endtask

    task automatic reset_async;
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("arst_rel");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] old5;
        logic [7:0] b0;
        logic [7:0] b1;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        pc_addr = 8'h00; address_bus = 8'h00; data_out = 8'h00; ld_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        reset = 1'b0;

        // Fill the whole array so every later read has a known value; exactly 256 bytes must not overflow.
        start_load();
        for (int i = 0; i < 256; i++) send_byte(8'($urandom), i == 255, $urandom_range(0, 2));
        check("full.count", 32'(ld_count), 32'd256);
        check("full.ovf", 32'(ld_overflow), 32'd0);
        run_op(8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b1);

        // Directed three-byte load after reset.
        reset_async();
        start_load();
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h80, 1'b0, 0);
        send_byte(8'hF0, 1'b1, 0);
        check("load3.count", 32'(ld_count), 32'd3);
        check("load3.hold", 32'(cpu_hold), 32'd0);
`ifdef AHMES_MEM_CHECKSUM_EN
        check("load3.sum", 32'(ld_sum), 32'h90);
`endif
        run_op(LB + 8'd1, LB + 8'd2, 8'h00, 1'b0, 1'b1);
        check("fetch.instr", 32'(instr_bus), 32'h80);
        check("read.data", 32'(data_bus), 32'hF0);

        // Read-first on both ports.
        run_op(8'h00, 8'h10, 8'h00, 1'b1, 1'b0);
        run_op(8'h10, 8'h10, 8'h5A, 1'b1, 1'b1);
        check("rf.data", 32'(data_bus), 32'h00);
        check("rf.instr", 32'(instr_bus), 32'h00);
        run_op(8'h10, 8'h10, 8'h00, 1'b0, 1'b1);
        check("rf.after", 32'(data_bus), 32'h5A);
        check("rf.instr2", 32'(instr_bus), 32'h5A);

        for (int i = 0; i < 150; i++)
            run_op(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Data-port writes are ignored during a load.
        old5 = m_mem[8'h05];
        start_load();
        idle_inputs();
        mem_we = 1'b1; mem_re = 1'b1; address_bus = 8'h05; data_out = ~old5;
        tick();
        check_all("ldwe");
        idle_inputs();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), i == 2, 1);
        run_op(8'h05, 8'h05, 8'h00, 1'b0, 1'b1);
        check("ldwe.mem5", 32'(data_bus), 32'(old5));

        // 257-byte load wraps onto LOAD_BASE and flags overflow.
        start_load();
        b = 8'h00;
        for (int i = 0; i < 257; i++) begin
            b = 8'($urandom);
            send_byte(b, i == 256, 0);
        end
        check("ovf.count", 32'(ld_count), 32'd256);
        check("ovf.flag", 32'(ld_overflow), 32'd1);
        run_op(LB, LB, 8'h00, 1'b0, 1'b1);
        check("ovf.mem", 32'(data_bus), 32'(b));
        start_load();
        check("ovf.clear", 32'(ld_overflow), 32'd0);
        send_byte(8'($urandom), 1'b1, 0);

        // Reset in the middle of a load keeps the bytes already written.
        start_load();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send_byte(b0, 1'b0, 0);
        send_byte(b1, 1'b0, 0);
        reset_async();
        check("abort.count", 32'(ld_count), 32'd0);
        run_op(LB, LB, 8'h00, 1'b0, 1'b1);
        check("abort.b0", 32'(data_bus), 32'(b0));
        run_op(LB + 8'd1, LB + 8'd1, 8'h00, 1'b0, 1'b1);
        check("abort.b1", 32'(data_bus), 32'(b1));

        // Random mix of short loads and CPU traffic.
        for (int k = 0; k < 10; k++) begin
            int n;
            for (int i = 0; i < 10; i++)
                run_op(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n = $urandom_range(1, 12);
            start_load();
            for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1, $urandom_range(0, 3));
        end
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
